// File: rtl/axi_lite_master.sv
// axi_lite_master
//   AXI4-Lite initiator. Takes one register command at a time from a
//   valid/ready command port, runs the matching AXI4-Lite read or write, and
//   returns the data and response on a valid/ready response port.
//
// Ports
//   clk, reset               rising-edge clock, asynchronous active-high reset
//   cmd_*                    command: valid/ready, write, addr, wdata, wstrb
//   rsp_*                    response: valid/ready, write, rdata, resp
//   err_count                saturating count of SLVERR/DECERR responses
//   axi_aw*/axi_w*/axi_b*    write address, write data, write response
//   axi_ar*/axi_r*           read address, read data
//
// All outputs are registered. Each channel's payload is cleared when its
// valid drops, so the direction not in use always presents zeros.
module axi_lite_master #(
  parameter int         WIDTH    = 32,
  parameter logic [2:0] PROT     = 3'b000,
  parameter int         ERRCNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [WIDTH-1:0]     cmd_addr,
  input  logic [WIDTH-1:0]     cmd_wdata,
  input  logic [WIDTH/8-1:0]   cmd_wstrb,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_write,
  output logic [WIDTH-1:0]     rsp_rdata,
  output logic [1:0]           rsp_resp,
  output logic [ERRCNT_W-1:0]  err_count,
  output logic [WIDTH-1:0]     axi_awaddr,
  output logic [2:0]           axi_awprot,
  output logic                 axi_awvalid,
  input  logic                 axi_awready,
  output logic [WIDTH-1:0]     axi_wdata,
  output logic [WIDTH/8-1:0]   axi_wstrb,
  output logic                 axi_wvalid,
  input  logic                 axi_wready,
  input  logic [1:0]           axi_bresp,
  input  logic                 axi_bvalid,
  output logic                 axi_bready,
  output logic [WIDTH-1:0]     axi_araddr,
  output logic [2:0]           axi_arprot,
  output logic                 axi_arvalid,
  input  logic                 axi_arready,
  input  logic [WIDTH-1:0]     axi_rdata,
  input  logic [1:0]           axi_rresp,
  input  logic                 axi_rvalid,
  output logic                 axi_rready
);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;

  state_t state;
  logic   aw_done, w_done;
  logic   aw_fin, w_fin;

  // A channel counts as finished if it handshook earlier or handshakes now.
  assign aw_fin = aw_done | (axi_awvalid & axi_awready);
  assign w_fin  = w_done  | (axi_wvalid  & axi_wready);

  function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] c,
                                                  input logic               err);
    if (!err || (&c)) return c;
    return c + {{(ERRCNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= 2'b00;
      err_count   <= '0;
      axi_awaddr  <= '0;
      axi_awprot  <= 3'b000;
      axi_awvalid <= 1'b0;
      axi_wdata   <= '0;
      axi_wstrb   <= '0;
      axi_wvalid  <= 1'b0;
      axi_bready  <= 1'b0;
      axi_araddr  <= '0;
      axi_arprot  <= 3'b000;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // cmd_ready is high exactly in IDLE, so cmd_valid is the handshake.
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            if (cmd_addr[1:0] != 2'b00) begin
              // Misaligned: answer locally with SLVERR, no bus traffic.
              state     <= RSP;
              rsp_valid <= 1'b1;
              rsp_write <= cmd_write;
              rsp_rdata <= '0;
              rsp_resp  <= 2'b10;
              err_count <= sat_inc(err_count, 1'b1);
            end else if (cmd_write) begin
              state       <= WR;
              aw_done     <= 1'b0;
              w_done      <= 1'b0;
              axi_awaddr  <= cmd_addr;
              axi_awprot  <= PROT;
              axi_awvalid <= 1'b1;
              axi_wdata   <= cmd_wdata;
              axi_wstrb   <= cmd_wstrb;
              axi_wvalid  <= 1'b1;
            end else begin
              state       <= RD_ADDR;
              axi_araddr  <= cmd_addr;
              axi_arprot  <= PROT;
              axi_arvalid <= 1'b1;
            end
          end
        end

        WR: begin
          if (axi_awvalid && axi_awready) begin
            axi_awvalid <= 1'b0;
            axi_awaddr  <= '0;
            axi_awprot  <= 3'b000;
          end
          if (axi_wvalid && axi_wready) begin
            axi_wvalid <= 1'b0;
            axi_wdata  <= '0;
            axi_wstrb  <= '0;
          end
          if (aw_fin && w_fin) begin
            state      <= WR_RESP;
            axi_bready <= 1'b1;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
          end else begin
            aw_done <= aw_fin;
            w_done  <= w_fin;
          end
        end

        WR_RESP: begin
          if (axi_bvalid) begin
            state      <= RSP;
            axi_bready <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_write  <= 1'b1;
            rsp_rdata  <= '0;
            rsp_resp   <= axi_bresp;
            err_count  <= sat_inc(err_count, axi_bresp[1]);
          end
        end

        RD_ADDR: begin
          if (axi_arready) begin
            state       <= RD_DATA;
            axi_arvalid <= 1'b0;
            axi_araddr  <= '0;
            axi_arprot  <= 3'b000;
            axi_rready  <= 1'b1;
          end
        end

        RD_DATA: begin
          if (axi_rvalid) begin
            state      <= RSP;
            axi_rready <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_write  <= 1'b0;
            rsp_rdata  <= axi_rdata;
            rsp_resp   <= axi_rresp;
            err_count  <= sat_inc(err_count, axi_rresp[1]);
          end
        end

        RSP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b00;
          end
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
module tb_axi_lite_master;
  localparam int W  = 32;
  localparam int EW = 4;
  localparam int EMAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [W-1:0]  cmd_addr, cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [W-1:0]  rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [EW-1:0] err_count;
  logic [W-1:0]  axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
  logic [2:0]    axi_awprot, axi_arprot;
  logic          axi_awvalid, axi_awready, axi_wvalid, axi_wready;
  logic [3:0]    axi_wstrb;
  logic [1:0]    axi_bresp, axi_rresp;
  logic          axi_bvalid, axi_bready, axi_arvalid, axi_arready;
  logic          axi_rvalid, axi_rready;

  always #5 clk = ~clk;

  axi_lite_master #(.WIDTH(W), .PROT(3'b000), .ERRCNT_W(EW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .err_count(err_count),
    .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bresp(axi_bresp),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_araddr(axi_araddr),
    .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready)
  );

  // One command plus the responder behaviour to apply to it.
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          awd, wd, bd, ard, rd;  // responder wait cycles per channel
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          hold;                  // cycles rsp_ready is held low
  } txn_t;

  typedef struct {
    txn_t        t;
    logic [1:0]  e_resp;
    logic [31:0] e_rdata;
    int          e_lat;
    int          e_err;
  } vec_t;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic        wr;
    int          lat;
    logic [3:0]  err;
    int          viol, awhs, whs, arhs, awcyc, wcyc, arcyc;
    logic        timeout;
  } obs_t;

  int checks = 0;
  int errors = 0;
  int model_err = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic clear_resp_inputs();
    axi_awready = 0; axi_wready = 0; axi_arready = 0;
    axi_bvalid = 0; axi_bresp = 0; axi_rvalid = 0; axi_rresp = 0; axi_rdata = 0;
    rsp_ready = 0;
  endtask

  // Drives one command and plays the responder. Stimulus changes on the
  // falling edge; DUT outputs are sampled there too.
  task automatic run_txn(input txn_t t, output obs_t o);
    int cyc, awc, wc, arc, bc, rc, bhs, rhs, held, wait_n;
    logic aligned, seen, acked, done, b_arm, r_arm;
    aligned = (t.addr[1:0] == 2'b00);
    o.resp = 0; o.rdata = 0; o.wr = 0; o.lat = -1; o.err = 0; o.viol = 0;
    o.awhs = 0; o.whs = 0; o.arhs = 0; o.awcyc = 0; o.wcyc = 0; o.arcyc = 0;
    o.timeout = 0;
    awc = 0; wc = 0; arc = 0; bc = 0; rc = 0; bhs = 0; rhs = 0; held = 0;
    seen = 0; acked = 0; done = 0; b_arm = 0; r_arm = 0; cyc = 0; wait_n = 0;
    @(negedge clk);
    while (!cmd_ready && wait_n < 50) begin @(negedge clk); wait_n++; end
    if (!cmd_ready) begin o.timeout = 1; return; end
    cmd_valid = 1; cmd_write = t.wr; cmd_addr = t.addr;
    cmd_wdata = t.wdata; cmd_wstrb = t.wstrb;
    while (!done && cyc < 300) begin
      @(negedge clk); cyc++;
      cmd_valid = 0;
      if (acked) begin
        rsp_ready = 0;
        if (rsp_valid || !cmd_ready) o.viol++;
        done = 1;
      end else begin
        if (cmd_ready) o.viol++;
        if (t.wr && (axi_arvalid || axi_araddr != 0)) o.viol++;
        if (!t.wr && (axi_awvalid || axi_wvalid || axi_awaddr != 0 ||
                      axi_wdata != 0 || axi_wstrb != 0)) o.viol++;
        if (axi_awvalid) begin
          if (!aligned || axi_awaddr != t.addr || axi_awprot != 0) o.viol++;
          axi_awready = (awc >= t.awd);
          if (axi_awready) o.awhs++;
          awc++; o.awcyc++;
        end else axi_awready = 0;
        if (axi_wvalid) begin
          if (!aligned || axi_wdata != t.wdata || axi_wstrb != t.wstrb) o.viol++;
          axi_wready = (wc >= t.wd);
          if (axi_wready) o.whs++;
          wc++; o.wcyc++;
        end else axi_wready = 0;
        if (axi_arvalid) begin
          if (!aligned || axi_araddr != t.addr || axi_arprot != 0) o.viol++;
          axi_arready = (arc >= t.ard);
          if (axi_arready) o.arhs++;
          arc++; o.arcyc++;
        end else axi_arready = 0;
        if (axi_bready && !b_arm) o.viol++;
        if (axi_rready && !r_arm) o.viol++;
        if (b_arm && bhs == 0) begin
          axi_bvalid = (bc >= t.bd); axi_bresp = t.resp; bc++;
          if (axi_bvalid && axi_bready) bhs++;
        end else axi_bvalid = 0;
        if (r_arm && rhs == 0) begin
          axi_rvalid = (rc >= t.rd); axi_rresp = t.resp; axi_rdata = t.rdata; rc++;
          if (axi_rvalid && axi_rready) rhs++;
        end else axi_rvalid = 0;
        if (rsp_valid) begin
          if (!seen) begin
            seen = 1; o.lat = cyc; o.resp = rsp_resp; o.rdata = rsp_rdata;
            o.wr = rsp_write; o.err = err_count;
          end else if (rsp_resp !== o.resp || rsp_rdata !== o.rdata || rsp_write !== o.wr)
            o.viol++;
          if (held >= t.hold) begin rsp_ready = 1; acked = 1; end
          else rsp_ready = 0;
          held++;
        end
        b_arm = (o.awhs > 0) && (o.whs > 0);
        r_arm = (o.arhs > 0);
      end
    end
    if (!done) o.timeout = 1;
    clear_resp_inputs();
  endtask

  task automatic apply(input string nm, input txn_t t, input logic [1:0] er,
                       input logic [31:0] ed, input int elat, input int eerr);
    obs_t o;
    logic bus;
    bus = (t.addr[1:0] == 2'b00);
    run_txn(t, o);
    chk({nm, " timeout"}, o.timeout, 0);
    chk({nm, " rsp_resp"}, o.resp, er);
    chk({nm, " rsp_rdata"}, o.rdata, ed);
    chk({nm, " rsp_write"}, o.wr, t.wr);
    chk({nm, " latency"}, o.lat, elat);
    chk({nm, " err_count"}, o.err, eerr);
    chk({nm, " protocol"}, o.viol, 0);
    chk({nm, " aw handshakes"}, o.awhs, (bus && t.wr) ? 1 : 0);
    chk({nm, " w handshakes"}, o.whs, (bus && t.wr) ? 1 : 0);
    chk({nm, " ar handshakes"}, o.arhs, (bus && !t.wr) ? 1 : 0);
    chk({nm, " awvalid cycles"}, o.awcyc, (bus && t.wr) ? t.awd + 1 : 0);
    chk({nm, " wvalid cycles"}, o.wcyc, (bus && t.wr) ? t.wd + 1 : 0);
    chk({nm, " arvalid cycles"}, o.arcyc, (bus && !t.wr) ? t.ard + 1 : 0);
  endtask

  // Reference behaviour: misaligned -> local SLVERR after one cycle; writes
  // wait for the slower of AW/W then B; reads wait for AR then R.
  function automatic void model(input txn_t t, output logic [1:0] r,
                                output logic [31:0] d, output int lat);
    if (t.addr[1:0] != 2'b00) begin r = 2'b10; d = 0; lat = 1; end
    else if (t.wr) begin r = t.resp; d = 0; lat = 3 + ((t.awd > t.wd) ? t.awd : t.wd) + t.bd; end
    else begin r = t.resp; d = t.rdata; lat = 3 + t.ard + t.rd; end
  endfunction

  initial begin
    vec_t tbl[8];
    txn_t t;
    logic [1:0] er;
    logic [31:0] ed;
    int el;

    reset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    clear_resp_inputs();

    //         wr    addr          wdata         strb  awd wd bd ard rd resp  rdata        hold
    tbl[0] = '{'{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0}, 2'b00, 32'h0, 3, 0};
    tbl[1] = '{'{1'b1, 32'h20, 32'hA5A5A5A5, 4'h3, 4, 0, 0, 0, 0, 2'b00, 32'h0, 0}, 2'b00, 32'h0, 7, 0};
    tbl[2] = '{'{1'b0, 32'h24, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h12345678, 3}, 2'b00, 32'h12345678, 3, 0};
    tbl[3] = '{'{1'b0, 32'h28, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b10, 32'hCAFEF00D, 0}, 2'b10, 32'hCAFEF00D, 3, 1};
    tbl[4] = '{'{1'b1, 32'h3, 32'h11112222, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0, 1}, 2'b10, 32'h0, 1, 2};
    tbl[5] = '{'{1'b1, 32'h40, 32'h0BADF00D, 4'h8, 1, 3, 2, 0, 0, 2'b11, 32'h0, 0}, 2'b11, 32'h0, 8, 3};
    tbl[6] = '{'{1'b0, 32'h44, 32'h0, 4'h0, 0, 0, 0, 2, 1, 2'b01, 32'h55AA55AA, 2}, 2'b01, 32'h55AA55AA, 6, 3};
    tbl[7] = '{'{1'b0, 32'h2, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0}, 2'b10, 32'h0, 1, 4};

    // Reset values.
    #1;
    chk("reset cmd_ready", cmd_ready, 1);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp fields", {rsp_write, rsp_rdata, rsp_resp}, 0);
    chk("reset err_count", err_count, 0);
    chk("reset aw/w", {axi_awvalid, axi_wvalid, axi_awaddr, axi_wdata, axi_wstrb, axi_awprot}, 0);
    chk("reset ar", {axi_arvalid, axi_araddr, axi_arprot}, 0);
    chk("reset bready/rready", {axi_bready, axi_rready}, 0);
    repeat (2) @(negedge clk);
    reset = 0;

    // Stray B/R valids in IDLE are ignored.
    axi_bvalid = 1; axi_bresp = 2'b10; axi_rvalid = 1; axi_rresp = 2'b10;
    repeat (3) begin
      @(negedge clk);
      chk("stray bready", axi_bready, 0);
      chk("stray rready", axi_rready, 0);
      chk("stray rsp_valid", rsp_valid, 0);
      chk("stray err_count", err_count, 0);
    end
    clear_resp_inputs();

    for (int i = 0; i < 8; i++)
      apply($sformatf("vec%0d", i), tbl[i].t, tbl[i].e_resp, tbl[i].e_rdata,
            tbl[i].e_lat, tbl[i].e_err);
    model_err = 4;

    // Randomized commands against the reference model.
    for (int i = 0; i < 40; i++) begin
      t.wr = 1'($urandom_range(0, 1));
      t.addr = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) t.addr[1:0] = 2'($urandom_range(1, 3));
      t.wdata = $urandom; t.wstrb = 4'($urandom);
      t.awd = $urandom_range(0, 3); t.wd = $urandom_range(0, 3); t.bd = $urandom_range(0, 2);
      t.ard = $urandom_range(0, 3); t.rd = $urandom_range(0, 2);
      t.resp = 2'($urandom); t.rdata = $urandom; t.hold = $urandom_range(0, 2);
      model(t, er, ed, el);
      if (er[1] && model_err < EMAX) model_err++;
      apply($sformatf("rnd%0d", i), t, er, ed, el, model_err);
    end

    // Reset while AW is stalled: outputs clear asynchronously, no response.
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h80; cmd_wdata = 32'h1; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 0; axi_awready = 0; axi_wready = 0;
    chk("midrst awvalid before", axi_awvalid, 1);
    #2 reset = 1;
    #1;
    chk("midrst awvalid", axi_awvalid, 0);
    chk("midrst wvalid", axi_wvalid, 0);
    chk("midrst cmd_ready", cmd_ready, 1);
    chk("midrst err_count", err_count, 0);
    @(negedge clk); reset = 0;
    repeat (4) begin
      @(negedge clk);
      chk("postrst rsp_valid", rsp_valid, 0);
      chk("postrst awvalid", axi_awvalid, 0);
      chk("postrst cmd_ready", cmd_ready, 1);
    end
    model_err = 0;

    // Saturation of the 4-bit error counter.
    for (int i = 1; i <= 17; i++) begin
      t = '{1'b0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b11, 32'h0, 0};
      if (i % 2 == 0) t.addr = 32'h101;
      model(t, er, ed, el);
      model_err = (model_err < EMAX) ? model_err + 1 : EMAX;
      apply($sformatf("sat%0d", i), t, er, ed, el, model_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
AXI4-Lite initiator that turns single register commands from a simple valid/ready command port into AXI4-Lite read or write transactions. It presents the returned data and response on a valid/ready response port. The block drives the initiator side of the register-space bus, and its bus ports connect one-to-one to the register-space responder signals. One transaction is outstanding at a time. It is used by the sequencing and control logic and by bring-up benches to access the register space.

Parameters:
WIDTH, 32, address and data width; strobe width is WIDTH/8
PROT, 3'b000, constant value driven on axi_awprot and axi_arprot
ERRCNT_W, 16, width of the saturating error counter

Ports:
clk  input  1  clock; all logic is rising-edge
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  block can accept a command
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  WIDTH  byte address
cmd_wdata  input  WIDTH  write data
cmd_wstrb  input  WIDTH/8  write byte strobes
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed
rsp_write  output  1  response belongs to a write
rsp_rdata  output  WIDTH  read data; 0 for writes
rsp_resp  output  2  AXI response code
err_count  output  ERRCNT_W  saturating count of responses with resp[1]=1
axi_awaddr, axi_awprot, axi_awvalid  output  WIDTH/3/1  write address channel
axi_awready  input  1
axi_wdata, axi_wstrb, axi_wvalid  output  WIDTH/WIDTH/8/1  write data channel
axi_wready  input  1
axi_bresp  input  2;  axi_bvalid  input  1;  axi_bready  output  1
axi_araddr, axi_arprot, axi_arvalid  output  WIDTH/3/1  read address channel
axi_arready  input  1
axi_rdata  input  WIDTH;  axi_rresp  input  2;  axi_rvalid  input  1;  axi_rready  output  1

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, cmd_ready=1, and every other output is 0, including all valids, bready, rready, rsp_* and err_count. All bus outputs come from registers.
- States: IDLE, WR (AW/W outstanding), WR_RESP, RD_ADDR, RD_DATA, RSP.
- cmd_ready = (state==IDLE). On cmd_valid&&cmd_ready, addr, data, strb and write are latched.
- Misaligned command (cmd_addr[1:0]!=0):
  - No bus activity.
  - Next state is RSP with rsp_resp=2'b10 and rsp_rdata=0.
  - err_count is incremented.
- Aligned write: the cycle after acceptance, axi_awvalid=1 and axi_wvalid=1, with axi_awaddr/axi_wdata/axi_wstrb from the latch.
  - Each valid drops the cycle after its own handshake; the two handshakes are tracked independently with aw_done and w_done flags.
  - Channel outputs stay stable while their valid is high.
  - When both handshakes are done (they may complete in the same cycle), move to WR_RESP.
- WR_RESP: axi_bready=1. On axi_bvalid, latch axi_bresp into rsp_resp, clear bready and go to RSP with rsp_write=1 and rsp_rdata=0.
- Aligned read: the cycle after acceptance, axi_arvalid=1 (RD_ADDR) until axi_arready.
- RD_DATA: axi_rready=1. On axi_rvalid, latch axi_rdata and axi_rresp and go to RSP with rsp_write=0.
- RSP: rsp_valid=1, with fields held stable until rsp_ready. When rsp_valid&&rsp_ready, return to IDLE and set cmd_ready=1 the next cycle.
- Minimum latency: acceptance to rsp_valid is 3 cycles for a write and 3 cycles for a read, assuming zero-wait responder handshakes.
- err_count increments when a response enters RSP with resp[1]=1 (SLVERR or DECERR). It saturates at all-ones and never wraps.
- bvalid or rvalid arriving outside WR_RESP or RD_DATA is ignored; ready stays low.
- There is no timeout. The block waits indefinitely for the responder.
- Reset asserted mid-transaction: all outputs return to reset values immediately. The in-flight transaction is dropped with no response, and err_count clears.
- The unused direction's channel outputs stay 0.

Test Plan:
- Write addr=0x10, data=0xDEADBEEF, strb=0xF, responder with zero wait and bresp=00 -> aw/w valid for 1 cycle with matching values; rsp_valid 3 cycles after acceptance with rsp_write=1, rsp_resp=00; err_count=0.
- Write with awready delayed 4 cycles and wready immediate -> wvalid drops after 1 cycle; awvalid held 5 cycles with a stable address; bready rises only after both handshakes complete.
- Read addr=0x24, rdata=0x12345678, rresp=00, with rsp_ready held low for 3 cycles -> rsp_rdata=0x12345678 held stable; cmd_ready=0 until the rsp handshake, then 1 the next cycle.
- Read with rresp=10, then write to addr 0x3 (misaligned) -> rsp_resp=10 for both; no AW/W activity for the second command; err_count=2.
- Reset asserted while awvalid=1 and awready=0 -> awvalid=0 immediately; no rsp_valid; cmd_ready=1 after release.
- Force err_count to all-ones via 2^ERRCNT_W error responses with ERRCNT_W=4 -> count holds at 15 on the 16th and 17th errors.
